led_zone_packer: RTL and testbench
==================================

Name: led_zone_packer

Overview:
- Parametrised successor of the zone-frame FIFO loader in the LED control path.
- Snapshots N_ZONES per-zone RGB means on `start` after a CPU arm (`en`).
- Emits a header word plus one packed RGB word per zone into an internal synchronous FIFO, in runtime-selectable zone and colour order.
- Drains the FIFO through a valid/ready stream toward the PHY/CDC stage and adds continuous mode, overrun detection and a frame counter.

Parameters:
- N_ZONES, 8, number of LED zones (2..64).
- CW, 4, bits per colour channel; word width W = 3*CW, W >= 8.
- DEPTH, 16, FIFO depth in words; power of 2, >= 2.
- HDR_TAG, 4'hA, 4-bit tag in the header word MSBs.

Ports:
- clk  in  1  block clock.
- rstn  in  1  synchronous active-low reset.
- en  in  1  arm pulse from CPU interrupt logic.
- start  in  1  frame-valid pulse from the statistics block.
- continuous  in  1  1 = re-arm automatically after each frame.
- reverse  in  1  1 = emit zones N_ZONES-1 down to 0.
- grb  in  1  1 = pack {G,R,B}; 0 = pack {R,G,B}, first colour in the MSBs.
- mean_r  in  N_ZONES*CW  packed zone R means, zone z at [z*CW +: CW].
- mean_g  in  N_ZONES*CW  packed zone G means.
- mean_b  in  N_ZONES*CW  packed zone B means.
- dout  out  W  stream data.
- dout_valid  out  1  stream valid; FIFO not empty.
- dout_ready  in  1  stream ready from the consumer.
- frame_done  out  1  one-cycle pulse when the last zone word is written to the FIFO.
- busy  out  1  high in ARMED or SEND.
- overrun  out  1  sticky; set when `start` arrives during SEND.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, sampled on posedge clk when rstn=0:
  - FSM goes to IDLE.
  - FIFO is emptied.
  - Zone index = 0, frame counter = 0.
  - All outputs are 0. dout is 0 while the FIFO is empty.
  - Reset mid-frame discards the partial frame. No frame_done pulse is produced.
- FSM states: IDLE, ARMED, SEND.
  - IDLE: en=1 -> ARMED. start is ignored.
  - ARMED: start=1 -> SEND. On the same edge, mean_r/g/b are captured into a snapshot register, zone index is loaded with 0 (or N_ZONES-1 if reverse=1), and reverse/grb are latched for the whole frame.
  - en in ARMED has no effect.
  - SEND, word 0: the header {HDR_TAG, frame_cnt[W-5:0]} is pushed when the FIFO is not full.
  - SEND, words 1..N_ZONES: zone words are pushed, one per cycle, only when the FIFO is not full. A full FIFO stalls the FSM and no data is dropped.
  - On the cycle the last zone word is pushed: frame_done=1, frame_cnt increments (wraps at 2^(W-4)), and the FSM goes to ARMED if continuous=1, otherwise IDLE.
  - start in SEND sets overrun; the frame continues. en in SEND is ignored.
  - start and en together in IDLE: only the arm takes effect (-> ARMED).
- Zone word = {c0, c1, c2}, each CW bits, taken from the snapshot of the current zone. Order is R,G,B, or G,R,B when grb=1.
- Minimum frame time is N_ZONES+1 cycles from the start edge, with no backpressure.
- FIFO:
  - First-word-fall-through: dout is valid combinationally from the head entry.
  - Pop when dout_valid & dout_ready.
  - Push is permitted only when level < DEPTH. A pop in the same cycle does not free space for that cycle's push.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH. The level is exact from 0 to DEPTH.
- overrun is cleared only by reset.

Decomposition:
- Shared package led_pkg:
  - state enum led_pack_state_t {IDLE, ARMED, SEND}.
  - HDR_TAG default constant.
  - Colour-order constants.
- Sub-module led_sync_fifo, parametrised by W and DEPTH, with ports push, din, pop, dout, full, empty, level.
- The FSM and packing logic stay in led_zone_packer.

Test Plan:
- Setup for all scenarios: N_ZONES=8, CW=4; zone z has R=z, G=z+8, B=15-z.
- Basic frame: en, then start, with dout_ready=1 -> words 0xA00, 0x08F, 0x19E, ..., 0x7F8; frame_done exactly 9 cycles after start; busy drops afterward.
- reverse=1, grb=1: second frame -> header 0xA01, then 0xF78, 0xE69, ..., 0x80F; frame_cnt=2 at the end.
- Backpressure: dout_ready=0, DEPTH=4 -> level saturates at 4 and the FSM stalls. Then raise dout_ready -> all 9 words arrive in order with none lost or duplicated.
- Overrun and continuous: pulse start during SEND -> overrun=1 and the frame is intact. With continuous=1, a second start is accepted with no en, giving header 0xA01 or higher.
- Ignored controls: start in IDLE -> no push, busy=0. Reset asserted mid-SEND -> level=0, dout_valid=0, no frame_done; the next armed frame restarts with header 0xA00.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED zone packer.
// Exports: led_pack_state_t, HDR_TAG_DEF, ORDER_RGB, ORDER_GRB.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SEND
  } led_pack_state_t;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  localparam logic ORDER_RGB = 1'b0;
  localparam logic ORDER_GRB = 1'b1;

endpackage

// File: rtl/led_sync_fifo.sv
// First-word-fall-through synchronous FIFO, exact occupancy count.
// Ports: clk, rstn (sync, low), push/din, pop/dout, full, empty, level.
module led_sync_fifo
  import led_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // A same-cycle pop never frees room for the push.
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        (do_push & ~do_pop): level <= level + 1'b1;
        (do_pop & ~do_push): level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/led_zone_packer.sv
// Snapshots per-zone RGB means and streams header + zone words via a FIFO.
// Ports: en/start/continuous/reverse/grb, mean_r/g/b in; dout stream, status out.
module led_zone_packer
  import led_pkg::*;
#(
  parameter int         N_ZONES = 8,
  parameter int         CW      = 4,
  parameter int         DEPTH   = 16,
  parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      start,
  input  logic                      continuous,
  input  logic                      reverse,
  input  logic                      grb,
  input  logic [N_ZONES*CW-1:0]     mean_r,
  input  logic [N_ZONES*CW-1:0]     mean_g,
  input  logic [N_ZONES*CW-1:0]     mean_b,
  output logic [3*CW-1:0]           dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      overrun,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int W  = 3 * CW;
  localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  led_pack_state_t       state;
  logic [ZW-1:0]         zidx;
  logic                  hdr;
  logic [W-5:0]          frame_cnt;
  logic                  rev_q;
  logic                  grb_q;
  logic [N_ZONES*CW-1:0] snap_r;
  logic [N_ZONES*CW-1:0] snap_g;
  logic [N_ZONES*CW-1:0] snap_b;

  logic [CW-1:0] c_r;
  logic [CW-1:0] c_g;
  logic [CW-1:0] c_b;
  logic [W-1:0]  zword;
  logic [W-1:0]  din;
  logic          push;
  logic          full;
  logic          empty;
  logic          last;

  assign c_r   = snap_r[zidx*CW +: CW];
  assign c_g   = snap_g[zidx*CW +: CW];
  assign c_b   = snap_b[zidx*CW +: CW];
  assign zword = (grb_q == ORDER_GRB) ? {c_g, c_r, c_b}
                                      : {c_r, c_g, c_b};
  assign din   = hdr ? {HDR_TAG, frame_cnt} : zword;
  assign push  = (state == SEND) & ~full;
  assign last  = rev_q ? (zidx == '0)
                       : (zidx == ZW'(N_ZONES - 1));

  assign dout_valid = ~empty;

  led_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (din),
    .pop   (dout_ready),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      zidx       <= '0;
      hdr        <= 1'b0;
      frame_cnt  <= '0;
      rev_q      <= 1'b0;
      grb_q      <= 1'b0;
      snap_r     <= '0;
      snap_g     <= '0;
      snap_b     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (start) begin
            state  <= SEND;
            snap_r <= mean_r;
            snap_g <= mean_g;
            snap_b <= mean_b;
            zidx   <= reverse ? ZW'(N_ZONES - 1) : '0;
            rev_q  <= reverse;
            grb_q  <= grb;
            hdr    <= 1'b1;
          end
        end
        SEND: begin
          if (start) overrun <= 1'b1;
          if (push) begin
            if (hdr) begin
              hdr <= 1'b0;
            end else if (last) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
              state      <= continuous ? ARMED : IDLE;
              busy       <= continuous;
            end else begin
              zidx <= rev_q ? zidx - 1'b1 : zidx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_zone_packer.sv
// Scoreboard bench for led_zone_packer (8 zones, CW=4, DEPTH=4).
// Expected words are queued at start and compared as the stream pops.
module tb_led_zone_packer;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        start;
  logic        continuous;
  logic        reverse;
  logic        grb;
  logic [31:0] mean_r;
  logic [31:0] mean_g;
  logic [31:0] mean_b;
  logic [11:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  logic [2:0]  fifo_level;

  int          errs;
  int          checks;
  int          done_cnt;
  int          fc;
  logic [11:0] exp_q[$];

  led_zone_packer #(
    .N_ZONES (8),
    .CW      (4),
    .DEPTH   (4),
    .HDR_TAG (4'hA)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .start      (start),
    .continuous (continuous),
    .reverse    (reverse),
    .grb        (grb),
    .mean_r     (mean_r),
    .mean_g     (mean_g),
    .mean_b     (mean_b),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (rstn && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 32'(exp_q.size()), 1);
      end else begin
        check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic model_frame(input logic rev, input logic g);
    logic [7:0]  f;
    logic [3:0]  r;
    logic [3:0]  gg;
    logic [3:0]  b;
    int          z;
    f = 8'(fc);
    exp_q.push_back({4'hA, f});
    for (int i = 0; i < 8; i++) begin
      z  = rev ? 7 - i : i;
      r  = 4'(z);
      gg = 4'(z + 8);
      b  = 4'(15 - z);
      exp_q.push_back(g ? {gg, r, b} : {r, gg, b});
    end
    fc++;
  endtask

  // Cycles counted from the start edge until frame_done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (frame_done) break;
    end
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || dout_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(exp_q.size()), 0);
    check({tag, "_lvl"}, 32'(fifo_level), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    errs = 0; checks = 0; done_cnt = 0; fc = 0;
    rstn = 1'b0; en = 1'b0; start = 1'b0;
    continuous = 1'b0; reverse = 1'b0; grb = 1'b0;
    dout_ready = 1'b1;
    for (int z = 0; z < 8; z++) begin
      mean_r[z*4 +: 4] = 4'(z);
      mean_g[z*4 +: 4] = 4'(z + 8);
      mean_b[z*4 +: 4] = 4'(15 - z);
    end
    tick(3);
    check("rst_dout",  32'(dout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ovr",   32'(overrun), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_done",  32'(frame_done), 0);
    rstn = 1'b1;
    tick(1);

    // Basic frame
    arm();
    check("armed_busy", 32'(busy), 1);
    model_frame(1'b0, 1'b0);
    pulse_start();
    wait_done(n);
    check("basic_lat", 32'(n), 9);
    check("basic_busy", 32'(busy), 0);
    wait_empty("basic_sb");
    check("basic_dones", 32'(done_cnt), 1);

    // Reverse + GRB
    reverse = 1'b1; grb = 1'b1;
    arm();
    model_frame(1'b1, 1'b1);
    pulse_start();
    reverse = 1'b0; grb = 1'b0;
    wait_done(n);
    check("rev_lat", 32'(n), 9);
    wait_empty("rev_sb");

    // Backpressure
    dout_ready = 1'b0;
    arm();
    model_frame(1'b0, 1'b0);
    d0 = done_cnt;
    pulse_start();
    tick(12);
    check("bp_level", 32'(fifo_level), 4);
    check("bp_busy",  32'(busy), 1);
    check("bp_nodone", 32'(done_cnt), 32'(d0));
    dout_ready = 1'b1;
    wait_done(n);
    check("bp_done", 32'(n < 200), 1);
    wait_empty("bp_sb");

    // Overrun + continuous
    continuous = 1'b1;
    arm();
    model_frame(1'b0, 1'b0);
    pulse_start();
    tick(2);
    pulse_start();
    wait_done(n);
    check("ovr_done", 32'(n < 200), 1);
    check("ovr_flag", 32'(overrun), 1);
    check("cont_busy", 32'(busy), 1);
    tick(1);
    model_frame(1'b0, 1'b0);
    pulse_start();
    continuous = 1'b0;
    wait_done(n);
    check("cont_lat", 32'(n), 9);
    check("cont_idle", 32'(busy), 0);
    wait_empty("cont_sb");

    // Start in IDLE is ignored
    tick(1);
    pulse_start();
    tick(3);
    check("idle_level", 32'(fifo_level), 0);
    check("idle_busy",  32'(busy), 0);
    check("idle_valid", 32'(dout_valid), 0);

    // Reset in the middle of SEND
    dout_ready = 1'b0;
    arm();
    pulse_start();
    tick(3);
    d0 = done_cnt;
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    fc = 0;
    check("mrst_level", 32'(fifo_level), 0);
    check("mrst_valid", 32'(dout_valid), 0);
    check("mrst_busy",  32'(busy), 0);
    check("mrst_ovr",   32'(overrun), 0);
    tick(12);
    check("mrst_nodone", 32'(done_cnt), 32'(d0));
    dout_ready = 1'b1;
    arm();
    model_frame(1'b0, 1'b0);
    pulse_start();
    wait_done(n);
    check("post_lat", 32'(n), 9);
    wait_empty("post_sb");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
